mux16_scan_seq: RTL and testbench

Scan sequencer that sits directly upstream and downstream of the team's 16-to-1 gate-level multiplexer. It drives the mux's 4-bit select through channels 0..15, lets each selection settle, and samples the mux's 1-bit output. It assembles the 16 samples into one 16-bit frame and hands the frame to downstream logic over a valid/ready handshake. It is the only sequential wrapper around the mux tree.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux_scan_next_chan.sv | 29 ++
 rtl/mux16_scan_seq.sv | 136 +++++++++++++
 tb/tb_mux16_scan_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and FSM state type for the 16:1 mux scan sequencer.
package mux_scan_pkg;
    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/mux_scan_next_chan.sv
// Channel-mask search for the scan sequencer; built only when MUX_SCAN_MASK_EN is defined.
// Returns the next set channel above i_ch and the lowest set channel of the mask.
`ifdef MUX_SCAN_MASK_EN
module mux_scan_next_chan
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_ch,
    output logic [SEL_W-1:0]  o_next,
    output logic              o_none_left,
    output logic [SEL_W-1:0]  o_first
);
    // Descending walk: the last hit written is the lowest qualifying index.
    always_comb begin
        o_next      = '0;
        o_none_left = 1'b1;
        o_first     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i > int'(i_ch))) begin
                o_next      = SEL_W'(i);
                o_none_left = 1'b0;
            end
            if (i_mask[i]) begin
                o_first = SEL_W'(i);
            end
        end
    end
endmodule
`endif

// File: rtl/mux16_scan_seq.sv
// Scan sequencer around the 16:1 mux: steps the select, samples mux_out, emits a 16-bit frame.
// Optional channel masking is enabled by defining MUX_SCAN_MASK_EN.
module mux16_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clr,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  mux_sel,
    output logic              busy,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [NUM_CH-1:0] frame_data
`ifdef MUX_SCAN_MASK_EN
    ,
    input  logic [NUM_CH-1:0] chan_mask
`endif
);
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam state_t     AFTER_CH    = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t              r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_ch, w_ch_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic [NUM_CH-1:0]   r_frame, w_frame_nxt;

    logic [SEL_W-1:0]    w_ch_next;
    logic [SEL_W-1:0]    w_ch_first;
    logic                w_last;
    logic                w_empty;

`ifdef MUX_SCAN_MASK_EN
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   w_scan_mask;

    // In IDLE the incoming mask picks the first channel while it is being latched.
    assign w_scan_mask = (r_state == IDLE) ? chan_mask : r_mask;
    assign w_empty     = ~|chan_mask;

    mux_scan_next_chan u_next_chan (
        .i_mask      (w_scan_mask),
        .i_ch        (r_ch),
        .o_next      (w_ch_next),
        .o_none_left (w_last),
        .o_first     (w_ch_first)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if (!clr && (r_state == IDLE) && start) begin
            r_mask <= chan_mask;
        end
    end
`else
    assign w_ch_next  = r_ch + 1'b1;
    assign w_last     = (r_ch == SEL_W'(NUM_CH - 1));
    assign w_ch_first = '0;
    assign w_empty    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_cnt   <= w_cnt_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_cnt_nxt   = r_cnt;
        w_frame_nxt = r_frame;
        if (clr) begin
            w_state_nxt = IDLE;
            w_ch_nxt    = '0;
            w_cnt_nxt   = '0;
            w_frame_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_frame_nxt = '0;
                        w_ch_nxt    = w_ch_first;
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_empty ? DONE : AFTER_CH;
                    end
                end
                SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_state_nxt = SAMPLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    w_frame_nxt[r_ch] = mux_out;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_ch_nxt    = w_ch_next;
                        w_cnt_nxt   = '0;
                        w_state_nxt = AFTER_CH;
                    end
                end
                DONE: begin
                    if (frame_ready) begin
                        w_state_nxt = IDLE;
                        w_ch_nxt    = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // The channel register is the select, so it only moves on clock edges.
    assign mux_sel     = r_ch;
    assign busy        = (r_state == SETTLE) || (r_state == SAMPLE);
    assign frame_valid = (r_state == DONE);
    assign frame_data  = r_frame;
endmodule

// File: tb/tb_mux16_scan_seq.sv
// Bench for mux16_scan_seq: two instances (SETTLE_CYCLES=1 and 0) share stimulus, each behind its own 16:1 mux model.
module tb_mux16_scan_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, clr, frame_ready;
    logic [15:0] pattern;
`ifdef MUX_SCAN_MASK_EN
    logic [15:0] chan_mask;
`endif

    logic [3:0]  sel1, sel0;
    logic        busy1, busy0, fv1, fv0, mo1, mo0;
    logic [15:0] fd1, fd0;

    logic        use0;
    logic [3:0]  cur_sel;
    logic        cur_busy, cur_fv;
    logic [15:0] cur_fd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mo1 = pattern[sel1];
    assign mo0 = pattern[sel0];

    assign cur_sel  = use0 ? sel0  : sel1;
    assign cur_busy = use0 ? busy0 : busy1;
    assign cur_fv   = use0 ? fv0   : fv1;
    assign cur_fd   = use0 ? fd0   : fd1;

    mux16_scan_seq #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .mux_out(mo1),
        .mux_sel(sel1), .busy(busy1), .frame_valid(fv1), .frame_ready(frame_ready),
        .frame_data(fd1)
`ifdef MUX_SCAN_MASK_EN
        , .chan_mask(chan_mask)
`endif
    );

    mux16_scan_seq #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .mux_out(mo0),
        .mux_sel(sel0), .busy(busy0), .frame_valid(fv0), .frame_ready(frame_ready),
        .frame_data(fd0)
`ifdef MUX_SCAN_MASK_EN
        , .chan_mask(chan_mask)
`endif
    );

    typedef struct {
        bit          s0;
        logic [15:0] pat;
        logic [15:0] exp_fd;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        frame_ready = 1'b1;
        while ((busy0 || busy1 || fv0 || fv1) && k < 100) begin
            tick();
            k++;
        end
        frame_ready = 1'b0;
        check("drain_timeout", (k < 100), 1);
    endtask

    task automatic run_vec(input bit s0, input logic [15:0] pat, input logic [15:0] exp_fd,
                           input int exp_lat, input bit chk_sel);
        int c, per, sel_bad;
        logic [3:0] exp_sel;
        use0        = s0;
        pattern     = pat;
        frame_ready = 1'b0;
        start       = 1'b1;
        tick();
        start   = 1'b0;
        c       = 1;
        sel_bad = 0;
        per     = s0 ? 1 : 2;
        while (!cur_fv && c < 200) begin
            exp_sel = 4'((c - 1) / per);
            if (chk_sel && (cur_sel !== exp_sel)) sel_bad++;
            tick();
            c++;
        end
        check("latency", c, exp_lat);
        check("frame_data", cur_fd, exp_fd);
        check("busy_in_done", cur_busy, 0);
        if (chk_sel) check("sel_steps", sel_bad, 0);
        drain();
        check("sel_after_handshake", cur_sel, 0);
    endtask

    initial begin
        int c, bad;
        logic [15:0] seen;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, bad;
        rst_n = 1'b1; start = 1'b0; clr = 1'b0; frame_ready = 1'b0;
        pattern = 16'h0000; use0 = 1'b0;
`ifdef MUX_SCAN_MASK_EN
        chan_mask = 16'hFFFF;
`endif
        #2 rst_n = 1'b0;
        #1;
        check("rst_sel", sel1, 0);
        check("rst_busy", busy1, 0);
        check("rst_valid", fv1, 0);
        check("rst_data", fd1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        vecs[0] = '{s0: 1'b0, pat: 16'hA5C3, exp_fd: 16'hA5C3, lat: 33};
        vecs[1] = '{s0: 1'b0, pat: 16'h0000, exp_fd: 16'h0000, lat: 33};
        vecs[2] = '{s0: 1'b1, pat: 16'hFFFF, exp_fd: 16'hFFFF, lat: 17};
        vecs[3] = '{s0: 1'b1, pat: 16'h5A3C, exp_fd: 16'h5A3C, lat: 17};
        vecs[4] = '{s0: 1'b0, pat: 16'h8001, exp_fd: 16'h8001, lat: 33};
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i].s0, vecs[i].pat, vecs[i].exp_fd, vecs[i].lat, 1'b1);
        end

        // Back-pressure on the zero-settle instance.
        use0 = 1'b1; pattern = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0; c = 1;
        while (!fv0 && c < 200) begin tick(); c++; end
        check("hold_latency", c, 17);
        check("hold_data", fd0, 16'h0001);
        bad = 0;
        repeat (5) begin
            tick();
            if (!fv0 || fd0 !== 16'h0001) bad++;
        end
        check("hold_stable", bad, 0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("hs_valid", fv0, 0);
        check("hs_busy", busy0, 0);
        check("hs_sel", sel0, 0);
        drain();

        // Abort mid-scan with clr.
        use0 = 1'b0; pattern = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("pre_clr_data", fd1, 16'h000F);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_data", fd1, 0);
        check("clr_sel", sel1, 0);
        check("clr_busy", busy1, 0);
        check("clr_data0", fd0, 0);
        bad = 0;
        repeat (40) begin
            tick();
            if (fv1 || fv0 || busy1 || busy0) bad++;
        end
        check("clr_no_frame", bad, 0);
        run_vec(1'b0, 16'h3C96, 16'h3C96, 33, 1'b1);

        // Asynchronous reset mid-scan, with start ignored while held.
        use0 = 1'b0; pattern = 16'hA5C3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        check("pre_rst_sel", sel1, 5);
        check("pre_rst_data", fd1, 16'h0003);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", sel1, 0);
        check("arst_busy", busy1, 0);
        check("arst_valid", fv1, 0);
        check("arst_data", fd1, 0);
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();
        check("start_in_rst_ignored", {busy1, busy0}, 0);

        // Asynchronous reset while holding a frame in DONE.
        pattern = 16'hA5C3; start = 1'b1;
        tick();
        start = 1'b0; c = 1;
        while (!fv1 && c < 200) begin tick(); c++; end
        check("done_data", fd1, 16'hA5C3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_done_valid", fv1, 0);
        check("arst_done_data", fd1, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

`ifdef MUX_SCAN_MASK_EN
        begin
            logic [15:0] seen;
            chan_mask = 16'h8101; pattern = 16'hFFFF; use0 = 1'b0; start = 1'b1;
            tick();
            start = 1'b0; c = 1; seen = '0;
            while (!fv1 && c < 200) begin
                if (busy1) seen[sel1] = 1'b1;
                tick();
                c++;
            end
            check("mask_latency", c, 7);
            check("mask_data", fd1, 16'h8101);
            check("mask_visited", seen, 16'h8101);
            drain();

            chan_mask = 16'h0000; start = 1'b1;
            tick();
            check("empty_valid", fv1, 1);
            check("empty_data", fd1, 0);
            bad = 0;
            repeat (5) begin
                tick();
                if (!fv1 || busy1) bad++;
            end
            check("empty_start_ignored", bad, 0);
            start = 1'b0;
            drain();
            check("empty_after_hs", fv1, 0);
            chan_mask = 16'hFFFF;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
